// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the one datapath slice reused every cycle by serial_add_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sumf,
  output logic carryf
);

  assign sumf   = a ^ b ^ c;
  assign carryf = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder time-shared LSB-first over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input that turns the operation into op_a - op_b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic             sumf, carryf;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder u_full_adder (
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .c      (carry_q),
    .sumf   (sumf),
    .carryf (carryf)
  );

  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt_q == LastBit);

  // Subtraction is a + ~b + 1, so only the B and carry load values change.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = op_b;
  assign c_load = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (state_q == StIdle && accept) begin
      a_sr_d  = op_a;
      b_sr_d  = b_load;
      carry_d = c_load;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      a_sr_d            = a_sr_q >> 1;
      b_sr_d            = b_sr_q >> 1;
      s_sr_d            = s_sr_q >> 1;
      s_sr_d[WIDTH-1]   = sumf;
      carry_d           = carryf;
      cnt_d             = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = s_sr_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] op_a, op_b, sum;
  logic       sub;

  logic       w1_in_valid, w1_in_ready, w1_cin, w1_out_valid, w1_cout, w1_busy;
  logic [0:0] w1_op_a, w1_op_b, w1_sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .op_a      (w1_op_a),
    .op_b      (w1_op_b),
    .cin       (w1_cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (w1_out_valid),
    .out_ready (1'b1),
    .sum       (w1_sum),
    .cout      (w1_cout),
    .busy      (w1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, then return #1 after the edge where out_valid first rises.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                      input logic [7:0] exp_sum, input logic exp_cout, input string tag);
    int n;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    cin      = c;
    sub      = s;
    tick();
    in_valid = 1'b0;
    op_a     = 8'hxx;
    op_b     = 8'hxx;
    cin      = 1'bx;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n = i;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
  endtask

  initial begin
    logic [2:0] combo;
    logic [1:0] fa_exp;
    int n;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    op_a        = '0;
    op_b        = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    out_ready   = 1'b1;
    w1_in_valid = 1'b0;
    w1_op_a     = '0;
    w1_op_b     = '0;
    w1_cin      = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    add8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add_5a_3c");
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    add8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01");
    add8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "add_ff_ff_c1");
    add8(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, "add_80_80_c1");

    // Backpressure: DONE must hold its result while out_ready is low.
    tick();
    out_ready = 1'b0;
    add8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {24'd0, sum}, 32'h46);
      chk("bp_cout", {31'd0, cout}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);

    // Reset during the third RUN cycle; partial sum and carry are nonzero here.
    in_valid = 1'b1;
    op_a     = 8'hFF;
    op_b     = 8'hFF;
    cin      = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    add8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, "post_abort");
    tick();

`ifdef SERIAL_ADD_SUB_EN
    add8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01");
    add8(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, "sub_01_02");
    sub = 1'b0;
    tick();
`endif

    // WIDTH=1: full-adder truth table, RUN lasts one cycle.
    for (int k = 0; k < 8; k++) begin
      combo = 3'(k);
      fa_exp = 2'(combo[2]) + 2'(combo[1]) + 2'(combo[0]);
      for (int i = 0; i < 20 && !w1_in_ready; i++) tick();
      w1_in_valid = 1'b1;
      w1_op_a     = combo[2];
      w1_op_b     = combo[1];
      w1_cin      = combo[0];
      tick();
      w1_in_valid = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
        tick();
        n = i;
        if (w1_out_valid) break;
      end
      chk($sformatf("w1_latency_%0d", k), n, 1);
      chk($sformatf("w1_result_%0d", k), {30'd0, w1_cout, w1_sum}, {30'd0, fa_exp});
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer that time-shares a single full_adder cell to add two WIDTH-bit operands LSB-first, one bit per clock. Operands arrive on a valid/ready input handshake. The result and carry-out are presented on a valid/ready output handshake. This block is the area-minimal alternative to a ripple-carry array.

Parameters:
WIDTH, 8, operand and result width in bits (>= 1)
CNT_W, $clog2(WIDTH) with minimum 1, width of the bit counter (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  carry-in, sampled with operands
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock domain; reset asynchronous, active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0. Internal shift registers, carry flop and counter are all cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sr<=op_a, b_sr<=op_b, carry_q<=cin, cnt<=0, then go to RUN.
  - When not accepting, op_a, op_b and cin are don't-care.
- RUN (in_ready=0):
  - The full_adder is driven with a=a_sr[0], b=b_sr[0], c=carry_q.
  - Each cycle: s_sr<={sumf, s_sr[WIDTH-1:1]}; a_sr and b_sr shift right; carry_q<=carryf; cnt<=cnt+1.
  - When cnt==WIDTH-1, that is the final bit: go to DONE.
- DONE:
  - out_valid=1.
  - sum=s_sr and cout=carry_q, held stable until out_valid&&out_ready.
  - On that handshake: out_valid deasserts and state returns to IDLE.
- Latency: operands accepted at edge k → out_valid first high after edge k+WIDTH.
- Throughput: one add per WIDTH+2 cycles minimum, counting the accept edge and the output-handshake edge.
- No overlap: in_ready is 0 in RUN and DONE. A new accept is possible the cycle after output handshake.
- Backpressure: out_ready low holds DONE indefinitely; sum and cout must not change.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset asserted mid-RUN or mid-DONE aborts the operation. All outputs return to reset values immediately (asynchronous); no partial result is emitted.
- sum and cout are registered outputs; no combinational path from inputs to outputs.
- Arithmetic: {cout,sum} == op_a + op_b + cin, modulo 2^(WIDTH+1).

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at operand accept.
  - When sub=1: b_sr loads ~op_b and carry_q loads 1; cin is ignored.
  - Result is op_a - op_b. cout=1 means no borrow (op_a >= op_b, unsigned).
- Undefined: port absent; addition only.

Decomposition:
- Package serial_add_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default WIDTH constant
- One sub-module: the existing full_adder cell (ports a, b, c, sumf, carryf), instantiated once as the bit-slice datapath.
- Counter, shift registers and FSM stay in serial_add_ctrl.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0, out_ready=1 → out_valid exactly 8 edges after accept; sum=0x96, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 → sum=0x00, cout=1. Then op_a=0xFF, op_b=0xFF, cin=1 → sum=0xFF, cout=1.
- Hold out_ready=0 for 5 cycles in DONE → out_valid stays 1; sum and cout stable; in_ready stays 0. Raise out_ready → next cycle in_ready=1, busy=0.
- Assert rst_n=0 during the 3rd RUN cycle → out_valid=0, sum=0, cout=0, in_ready=1 immediately. After release, a new add of 0x01+0x01 yields 0x02.
- WIDTH=1, all 8 combinations of a, b, cin → {cout,sum} matches the full-adder truth table (e.g. 1,1,1 → sum=1, cout=1).
- With SERIAL_ADD_SUB_EN:
  - 0x10 - 0x01 → sum=0x0F, cout=1.
  - 0x01 - 0x02 → sum=0xFF, cout=0.
